// File: rtl/simd_lane_unpacker_if.sv
// Stream bundle between the packed SIMD producer and the lane unpacker.
// Handshake: a beat transfers on a rising clk edge where valid && ready; valid, once raised, holds its payload until it transfers.
interface simd_lane_unpacker_if #(
  parameter int SEG_W = 12,
  parameter int NSEG  = 4,
  parameter int OUT_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEG_W*NSEG-1:0]   in_data;
  logic [NSEG-1:0]         in_carry;
  logic                    in_mode;
  logic                    in_signed;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic [1:0]              out_lane;
  logic                    out_last;
  logic                    out_ovf;

  modport slave (
    input  in_valid, in_data, in_carry, in_mode, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, out_ovf
  );

  modport master (
    output in_valid, in_data, in_carry, in_mode, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, out_ovf
  );
endinterface

// File: rtl/simd_lane_unpacker.sv
// Splits one packed SIMD word (4x12 or 2x24) into widened lanes, one per clock.
// Optional macro SIMD_UNPACK_SAT_EN saturates unsigned TWO24 lanes that carried out.
module simd_lane_unpacker #(
  parameter int SEG_W = 12,
  parameter int NSEG  = 4,
  parameter int OUT_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  simd_lane_unpacker_if.slave    bus,
  output logic                   dbg_state_o
);
  localparam int WORD_W  = SEG_W * NSEG;
  localparam int LANE2_W = 2 * SEG_W;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t              state_q;
  logic [1:0]          lane_q;
  logic [WORD_W-1:0]   data_q;
  logic [NSEG-1:0]     carry_q;
  logic                mode_q;
  logic                signed_q;

  logic                emit;
  logic                is_last;
  logic                accept;
  logic [1:0]          last_lane;
  logic [SEG_W-1:0]    segs [NSEG];
  logic [LANE2_W-1:0]  dlanes [2];
  logic [SEG_W-1:0]    seg;
  logic [LANE2_W-1:0]  dlane;
  logic [OUT_W-1:0]    lane_val;
  logic                lane_ovf;

  assign emit      = (state_q == EMIT);
  assign last_lane = mode_q ? 2'd1 : 2'd3;
  assign is_last   = emit && (lane_q == last_lane);
  // A new word is taken only as the final lane leaves, so ready never depends on in_valid.
  assign bus.in_ready = !emit || (bus.out_ready && is_last);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    for (int k = 0; k < NSEG; k++) segs[k] = data_q[k*SEG_W +: SEG_W];
    for (int k = 0; k < 2; k++) dlanes[k] = data_q[k*LANE2_W +: LANE2_W];
  end

  always_comb begin
    seg      = segs[lane_q];
    dlane    = dlanes[lane_q[0]];
    lane_val = '0;
    lane_ovf = 1'b0;
    if (!mode_q) begin
      if (signed_q) begin
        lane_val = OUT_W'($signed(seg));
      end else begin
        // Carry joins the segment as bit SEG_W, giving the exact unsigned sum.
        lane_val = OUT_W'({carry_q[lane_q], seg});
        lane_ovf = carry_q[lane_q];
      end
    end else begin
      if (signed_q) begin
        lane_val = OUT_W'($signed(dlane));
      end else begin
        lane_ovf = carry_q[{lane_q[0], 1'b1}];
`ifdef SIMD_UNPACK_SAT_EN
        lane_val = lane_ovf ? OUT_W'({LANE2_W{1'b1}}) : OUT_W'(dlane);
`else
        lane_val = OUT_W'(dlane);
`endif
      end
    end
  end

  assign bus.out_valid = emit;
  assign bus.out_data  = emit ? lane_val : '0;
  assign bus.out_lane  = emit ? lane_q : 2'd0;
  assign bus.out_last  = is_last;
  assign bus.out_ovf   = emit && lane_ovf;
  assign dbg_state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lane_q   <= 2'd0;
      data_q   <= '0;
      carry_q  <= '0;
      mode_q   <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q   <= bus.in_data;
            carry_q  <= bus.in_carry;
            mode_q   <= bus.in_mode;
            signed_q <= bus.in_signed;
            lane_q   <= 2'd0;
            state_q  <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (lane_q != last_lane) begin
              lane_q <= lane_q + 2'd1;
            end else if (accept) begin
              data_q   <= bus.in_data;
              carry_q  <= bus.in_carry;
              mode_q   <= bus.in_mode;
              signed_q <= bus.in_signed;
              lane_q   <= 2'd0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
